// File: rtl/avalon_tester_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avalon_tester_pkg : states, burst-length helper and test pattern. Rev 1.0
// ---------------------------------------------------------------------------
package avalon_tester_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        RD_CMD   = 3'd2,
        RD_DATA  = 3'd3,
        FINISH   = 3'd4
    } state_t;

    // Maximal burst is 2**(BURSTCOUNT_W-1), clipped to the memory size.
    function automatic int burst_len(input int ram_add_w, input int burstcount_w);
        int bl_max;
        int words;
        bl_max = 1 << (burstcount_w - 1);
        words  = 1 << ram_add_w;
        return (words < bl_max) ? words : bl_max;
    endfunction

    function automatic logic [31:0] pattern(input logic [15:0] idx, input logic [31:0] seed);
        return seed ^ {~idx, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avalon_if : burst-capable Avalon-MM bus between a host and a BRAM agent. Rev 1.0
// ---------------------------------------------------------------------------
interface avalon_if #(
    parameter int BURSTCOUNT_W = 4
) (
    input logic clk
);
    logic [31:0]             address;
    logic [3:0]              byteenable;
    logic                    write;
    logic [31:0]             writedata;
    logic                    read;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic [BURSTCOUNT_W-1:0] burstcount;

    modport host (
        output address, byteenable, write, writedata, read, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport agent (
        input  clk, address, byteenable, write, writedata, read, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/avalon_burst_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avalon_burst_tester : fills memory with write bursts, reads it back and counts mismatches. Rev 1.0
// ---------------------------------------------------------------------------
module avalon_burst_tester
    import avalon_tester_pkg::*;
#(
    parameter int          RAM_ADD_W    = 8,
    parameter int          BURSTCOUNT_W = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] error_count,
    output logic [31:0] first_err_addr,
    avalon_if.host      avalon_h
);

    localparam int WORDS  = 2 ** RAM_ADD_W;
    localparam int BL     = burst_len(RAM_ADD_W, BURSTCOUNT_W);
    localparam int NB     = WORDS / BL;
    localparam int BEAT_W = (BL > 1) ? $clog2(BL) : 1;
    localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BURSTCOUNT_W-1:0] BC_VAL = BURSTCOUNT_W'(BL);

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return BASE_ADDR + (idx << 2);
    endfunction

    state_t                  state_q, state_d;
    logic [BIDX_W-1:0]       b_q, b_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    write_q, write_d;
    logic                    read_q, read_d;
    logic [31:0]             address_q, address_d;
    logic [31:0]             writedata_q, writedata_d;
    logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [31:0]             first_err_q, first_err_d;

    logic [31:0] w_idx;
    logic [31:0] w_next_idx;
    logic [31:0] w_next_base;
    logic        w_last_beat;
    logic        w_last_burst;

    assign w_idx        = 32'(b_q) * 32'(BL) + 32'(beat_q);
    assign w_next_idx   = w_idx + 32'd1;
    assign w_next_base  = (32'(b_q) + 32'd1) * 32'(BL);
    assign w_last_beat  = (beat_q == BEAT_W'(BL - 1));
    assign w_last_burst = (b_q == BIDX_W'(NB - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            b_q          <= '0;
            beat_q       <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            burstcount_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            beat_q       <= beat_d;
            write_q      <= write_d;
            read_q       <= read_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            burstcount_q <= burstcount_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        beat_d       = beat_q;
        write_d      = write_q;
        read_d       = read_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        burstcount_d = burstcount_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_cnt_d    = '0;
                    first_err_d  = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    b_d          = '0;
                    beat_d       = '0;
                    write_d      = 1'b1;
                    address_d    = word_addr(32'd0);
                    writedata_d  = pattern(16'd0, SEED);
                    burstcount_d = BC_VAL;
                    state_d      = WR_BURST;
                end
            end
            WR_BURST: begin
                // Outputs only move on an accepted beat; a stalled beat holds everything.
                if (write_q && !avalon_h.waitrequest) begin
                    if (w_last_beat) begin
                        beat_d = '0;
                        if (w_last_burst) begin
                            write_d   = 1'b0;
                            b_d       = '0;
                            read_d    = 1'b1;
                            address_d = word_addr(32'd0);
                            state_d   = RD_CMD;
                        end else begin
                            b_d         = b_q + 1'b1;
                            address_d   = word_addr(w_next_base);
                            writedata_d = pattern(w_next_base[15:0], SEED);
                        end
                    end else begin
                        beat_d      = beat_q + 1'b1;
                        writedata_d = pattern(w_next_idx[15:0], SEED);
                    end
                end
            end
            RD_CMD: begin
                if (!avalon_h.waitrequest) begin
                    read_d  = 1'b0;
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (avalon_h.readdatavalid) begin
                    if (avalon_h.readdata != pattern(w_idx[15:0], SEED)) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = word_addr(w_idx);
                        end
                    end
                    if (w_last_beat) begin
                        beat_d = '0;
                        if (w_last_burst) begin
                            state_d = FINISH;
                        end else begin
                            b_d       = b_q + 1'b1;
                            read_d    = 1'b1;
                            address_d = word_addr(w_next_base);
                            state_d   = RD_CMD;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avalon_h.address    = address_q;
    assign avalon_h.byteenable = 4'hF;
    assign avalon_h.write      = write_q;
    assign avalon_h.writedata  = writedata_q;
    assign avalon_h.read       = read_q;
    assign avalon_h.burstcount = burstcount_q;

    assign busy           = busy_q;
    assign done           = done_q;
    assign error_count    = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_burst_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_avalon_burst_tester : directed bench with a behavioural burst BRAM agent. Rev 1.0
// ---------------------------------------------------------------------------
module tb_avalon_burst_tester;

    localparam logic [31:0] BASE_M = 32'h0000_1000;
    localparam logic [31:0] SEED_V = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_m = 1'b0;
    logic start_s = 1'b0;
    logic busy_m, done_m, busy_s, done_s;
    logic [15:0] err_m, err_s;
    logic [31:0] ferr_m, ferr_s;

    // bench control flags, changed only on negedges
    logic clr = 1'b0;
    logic rand_wait = 1'b0;
    logic corrupt = 1'b0;
    logic spur = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    avalon_if #(.BURSTCOUNT_W(4)) m_if (.clk(clk));
    avalon_if #(.BURSTCOUNT_W(4)) s_if (.clk(clk));

    avalon_burst_tester #(
        .RAM_ADD_W(8), .BURSTCOUNT_W(4), .BASE_ADDR(BASE_M), .SEED(SEED_V)
    ) u_dut_m (
        .clk(clk), .reset(reset), .start(start_m), .busy(busy_m), .done(done_m),
        .error_count(err_m), .first_err_addr(ferr_m), .avalon_h(m_if)
    );

    avalon_burst_tester #(
        .RAM_ADD_W(2), .BURSTCOUNT_W(4), .BASE_ADDR(32'h0), .SEED(SEED_V)
    ) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .error_count(err_s), .first_err_addr(ferr_s), .avalon_h(s_if)
    );

    function automatic logic [31:0] exp_pat(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return SEED_V ^ {~lo, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- main agent: 256-word burst BRAM ----------------
    logic [31:0] mem_m [256];
    int wr_beats = 0, wr_bursts = 0, rd_cmds = 0, bc_viol = 0, stab_viol = 0;
    int wbeat = 0, wbase = 0, rd_left = 0, ridx = 0;
    logic stalled = 1'b0;
    logic [31:0] p_addr, p_wd;
    logic [3:0] p_bc;
    logic p_wr, p_rd;

    function automatic int m_widx(input logic [31:0] a);
        logic [31:0] t;
        t = (a - BASE_M) >> 2;
        return int'(t[7:0]);
    endfunction

    always @(posedge clk) begin
        logic [31:0] d;
        if (reset || clr) begin
            m_if.waitrequest   <= 1'b0;
            m_if.readdatavalid <= 1'b0;
            m_if.readdata      <= '0;
            rd_left = 0;
            wbeat   = 0;
            stalled = 1'b0;
            if (clr) begin
                for (int i = 0; i < 256; i++) mem_m[i] = '0;
                wr_beats = 0; wr_bursts = 0; rd_cmds = 0; bc_viol = 0; stab_viol = 0;
            end
        end else begin
            if (stalled && (m_if.address !== p_addr || m_if.writedata !== p_wd ||
                            m_if.burstcount !== p_bc || m_if.write !== p_wr || m_if.read !== p_rd))
                stab_viol++;
            stalled = (m_if.write || m_if.read) && m_if.waitrequest;
            p_addr = m_if.address; p_wd = m_if.writedata; p_bc = m_if.burstcount;
            p_wr = m_if.write; p_rd = m_if.read;

            if (m_if.write && !m_if.waitrequest) begin
                if (wbeat == 0) begin
                    wbase = m_widx(m_if.address);
                    if (m_if.burstcount != 4'd8) bc_viol++;
                end
                mem_m[(wbase + wbeat) & 255] = m_if.writedata;
                wr_beats++;
                wbeat++;
                if (wbeat == 8) begin
                    wbeat = 0;
                    wr_bursts++;
                end
            end

            if (rd_left > 0) begin
                d = mem_m[ridx & 255];
                if (corrupt && (ridx == 17 || ridx == 200)) d = d ^ 32'h1;
                m_if.readdatavalid <= 1'b1;
                m_if.readdata      <= d;
                ridx++;
                rd_left--;
            end else if (spur) begin
                m_if.readdatavalid <= 1'b1;
                m_if.readdata      <= 32'hDEAD_BEEF;
            end else begin
                m_if.readdatavalid <= 1'b0;
            end

            if (m_if.read && !m_if.waitrequest) begin
                ridx    = m_widx(m_if.address);
                rd_left = int'(m_if.burstcount);
                rd_cmds++;
                if (m_if.burstcount != 4'd8) bc_viol++;
            end

            m_if.waitrequest <= rand_wait && ($urandom_range(0, 99) < 40);
        end
    end

    // ---------------- small agent: 4-word BRAM, never stalls ----------------
    logic [31:0] mem_s [4];
    int s_wr_beats = 0, s_rd_beats = 0, s_wbeat = 0, s_wbase = 0, s_rd_left = 0, s_ridx = 0;
    logic [3:0] s_bc_seen = '0;

    always @(posedge clk) begin
        if (reset) begin
            s_if.waitrequest   <= 1'b0;
            s_if.readdatavalid <= 1'b0;
            s_if.readdata      <= '0;
            s_rd_left = 0;
            s_wbeat   = 0;
        end else begin
            if (s_if.write) begin
                if (s_wbeat == 0) begin
                    s_wbase   = int'(s_if.address[3:2]);
                    s_bc_seen = s_if.burstcount;
                end
                mem_s[(s_wbase + s_wbeat) & 3] = s_if.writedata;
                s_wr_beats++;
                s_wbeat++;
                if (s_wbeat >= int'(s_bc_seen)) s_wbeat = 0;
            end
            if (s_rd_left > 0) begin
                s_if.readdatavalid <= 1'b1;
                s_if.readdata      <= mem_s[s_ridx & 3];
                s_ridx++;
                s_rd_left--;
                s_rd_beats++;
            end else begin
                s_if.readdatavalid <= 1'b0;
            end
            if (s_if.read) begin
                s_ridx    = int'(s_if.address[3:2]);
                s_rd_left = int'(s_if.burstcount);
            end
            s_if.waitrequest <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start_m();
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
    endtask

    task automatic clear_agent();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_done_m(input string tag);
        int n;
        n = 0;
        while (!done_m && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done_m}, 32'd1);
    endtask

    function automatic int mem_bad_count();
        int c;
        c = 0;
        for (int i = 0; i < 256; i++) if (mem_m[i] !== exp_pat(i)) c++;
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        #12;
        check("rst_read",  {31'd0, m_if.read},  32'd0);
        check("rst_write", {31'd0, m_if.write}, 32'd0);
        check("rst_addr",  m_if.address, 32'd0);
        check("rst_wdata", m_if.writedata, 32'd0);
        check("rst_be",    {28'd0, m_if.byteenable}, 32'hF);
        check("rst_bc",    {28'd0, m_if.burstcount}, 32'd0);
        check("rst_busy",  {31'd0, busy_m}, 32'd0);
        check("rst_done",  {31'd0, done_m}, 32'd0);
        check("rst_errc",  {16'd0, err_m}, 32'd0);
        check("rst_ferr",  ferr_m, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_agent();

        // run 1: no stalls, start re-pulsed mid write phase
        pulse_start_m();
        check("r1_busy", {31'd0, busy_m}, 32'd1);
        repeat (10) @(negedge clk);
        check("r1_write_mid", {31'd0, m_if.write}, 32'd1);
        pulse_start_m();
        wait_done_m("r1_done");
        check("r1_busy_low", {31'd0, busy_m}, 32'd0);
        check("r1_errc",     {16'd0, err_m}, 32'd0);
        check("r1_ferr",     ferr_m, 32'd0);
        check("r1_wbeats",   32'(wr_beats), 32'd256);
        check("r1_wbursts",  32'(wr_bursts), 32'd32);
        check("r1_rcmds",    32'(rd_cmds), 32'd32);
        check("r1_bc",       32'(bc_viol), 32'd0);
        check("r1_word17",   mem_m[17], 32'h5A4B_0011);
        check("r1_word0",    mem_m[0],  32'h5A5A_0000);
        check("r1_mem",      32'(mem_bad_count()), 32'd0);

        // stray readdatavalid while idle must not count
        spur = 1'b1;
        repeat (4) @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_errc", {16'd0, err_m}, 32'd0);
        check("spur_done", {31'd0, done_m}, 32'd1);

        // run 2: random waitrequest
        clear_agent();
        rand_wait = 1'b1;
        pulse_start_m();
        check("r2_done_clr", {31'd0, done_m}, 32'd0);
        check("r2_busy",     {31'd0, busy_m}, 32'd1);
        wait_done_m("r2_done");
        rand_wait = 1'b0;
        check("r2_stable", 32'(stab_viol), 32'd0);
        check("r2_wbeats", 32'(wr_beats), 32'd256);
        check("r2_mem",    32'(mem_bad_count()), 32'd0);
        check("r2_errc",   {16'd0, err_m}, 32'd0);

        // run 3: agent corrupts words 17 and 200 on read
        corrupt = 1'b1;
        pulse_start_m();
        wait_done_m("r3_done");
        corrupt = 1'b0;
        check("r3_errc", {16'd0, err_m}, 32'd2);
        check("r3_ferr", ferr_m, 32'h0000_1044);

        // run 4: reset asserted during the read data phase
        pulse_start_m();
        n = 0;
        while (!(rd_cmds >= 5 && m_if.readdatavalid) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("r4_reach_rd", {31'd0, (n < 6000)}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("r4_read",  {31'd0, m_if.read},  32'd0);
        check("r4_write", {31'd0, m_if.write}, 32'd0);
        check("r4_busy",  {31'd0, busy_m}, 32'd0);
        check("r4_done",  {31'd0, done_m}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start_m();
        wait_done_m("r5_done");
        check("r5_errc", {16'd0, err_m}, 32'd0);
        check("r5_ferr", ferr_m, 32'd0);

        // small instance: 4 words, one 4-beat burst each way
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!done_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s_done",   {31'd0, done_s}, 32'd1);
        check("s_errc",   {16'd0, err_s}, 32'd0);
        check("s_bc",     {28'd0, s_bc_seen}, 32'd4);
        check("s_wbeats", 32'(s_wr_beats), 32'd4);
        check("s_rbeats", 32'(s_rd_beats), 32'd4);
        check("s_word3",  mem_s[3], 32'h5A59_0003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
